clip_sequencer: RTL
===================

Name: clip_sequencer

Overview:
Multi-clip record/playback sequencer. It sits between the synchronized user commands, the Deserializer (record source) and Serializer (playback sink), and one shared sample memory partitioned into NUM_CLIPS equal regions. It generalises the two-bank, single-address scheme to N clips with a per-clip recorded-length table, and adds explicit stop and loop playback. Empty-clip protection is also new.

Parameters:
WORD_LENGTH, 16, sample width in bits
NUM_CLIPS, 4, number of clip regions (power of two, >=2)
CLIP_DEPTH, 65536, samples per clip (power of two)
(derived) CLIP_W = $clog2(NUM_CLIPS), OFF_W = $clog2(CLIP_DEPTH), LEN_W = OFF_W+1

Ports:
clock_i  in  1  system clock, 100 MHz
reset_i  in  1  reset; one clock; reset is synchronous and active-low
record_start_i  in  1  one-cycle pulse, start recording clip_select_i
play_start_i  in  1  one-cycle pulse, start playing clip_select_i
stop_i  in  1  one-cycle pulse, abort current operation
loop_i  in  1  level; 1 = playback wraps to offset 0 at end of clip
clip_select_i  in  CLIP_W  clip index, sampled on start pulse
rec_valid_i  in  1  Deserializer done strobe, rec_data_i valid
rec_data_i  in  WORD_LENGTH  recorded sample
play_ready_i  in  1  Serializer done strobe, requests next sample
play_data_o  out  WORD_LENGTH  sample presented to Serializer
record_enable_o  out  1  Deserializer enable
play_enable_o  out  1  Serializer enable
mem_en_o  out  1  memory enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  CLIP_W+OFF_W  {clip, offset}
mem_wdata_o  out  WORD_LENGTH  write data
mem_rdata_i  in  WORD_LENGTH  read data, valid 1 cycle after mem_en_o with mem_we_o=0
active_clip_o  out  CLIP_W  clip latched by last accepted start
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at end of a record or play, natural or stopped
full_o  out  1  one-cycle pulse when recording hits CLIP_DEPTH

Behaviour:
- Reset (reset_i=0 at posedge):
  - state IDLE; all length[] = 0; offset = 0; active_clip_o = 0.
  - All outputs 0; takes priority over everything.
- States:
  - IDLE: mem_en_o=0.
    - record_start_i: latch clip; offset=0; length[clip]=0; go RECORD.
    - else play_start_i with length[clip_select_i]!=0: latch clip; offset=0; go FETCH.
    - play_start_i on an empty clip: ignored, no done_o.
    - record_start_i and play_start_i in the same cycle: record wins.
  - RECORD: record_enable_o=1.
    - On rec_valid_i: mem_en_o=mem_we_o=1, addr={clip,offset}, wdata=rec_data_i; length[clip]=offset+1; offset++.
    - If offset was CLIP_DEPTH-1: pulse full_o and done_o; go IDLE.
  - FETCH: mem_en_o=1, mem_we_o=0, addr={clip,offset}; go LOAD.
  - LOAD: play_data_o <= mem_rdata_i; go HOLD.
  - HOLD: play_enable_o=1; play_data_o held.
    - On play_ready_i: next = offset+1.
    - If next==length[clip] and loop_i=1: offset=0; go FETCH.
    - If next==length[clip] and loop_i=0: pulse done_o; play_data_o=0; go IDLE.
    - Otherwise: offset=next; go FETCH.
- Start latency: FETCH and LOAD add 2 cycles before HOLD. play_enable_o is asserted in FETCH, LOAD and HOLD.
  - play_ready_i in FETCH/LOAD is ignored.
  - The Serializer's word period is >> 3 cycles, so no samples are lost.
- Busy handling:
  - stop_i in any non-IDLE state: go IDLE, pulse done_o, play_data_o=0.
  - stop_i has priority over rec_valid_i/play_ready_i in the same cycle; that sample is not written and the offset does not advance.
  - A stopped recording keeps the length written so far.
  - stop_i in IDLE: no effect.
  - Start pulses while busy: ignored. clip_select_i changes while busy: ignored.
- Width rules:
  - The offset counter is OFF_W bits and never wraps during recording; the full condition ends it.
  - Length is LEN_W bits, so CLIP_DEPTH itself is representable.
  - Comparisons are made at LEN_W with zero-extended offset.
- Recording over the clip currently selected for playback is impossible, because the operations are exclusive.

Decomposition:
- Package clip_pkg: state enum (IDLE, RECORD, FETCH, LOAD, HOLD) and helper function for the {clip, offset} address build.
- Sub-module clip_length_table (NUM_CLIPS x LEN_W register file, synchronous clear on reset, one write port, one async read port addressed by clip index). Used for the length lookup at play start and in HOLD.

Test Plan:
Bench uses NUM_CLIPS=4, CLIP_DEPTH=8, with a 1-cycle-latency memory model.
1. Record clip 2 (3 samples A,B,C), then stop -> writes at addr 16,17,18; done_o pulse; length[2]=3; busy_o=0.
2. Play clip 2 with loop_i=0 and 3 ready strobes -> play_data_o sequence A,B,C. Third strobe gives done_o, play_data_o=0, IDLE.
3. Record clip 1 with 8 samples -> addrs 8..15 written; full_o and done_o on the 8th; a 9th rec_valid_i writes nothing.
4. Play clip 1 with loop_i=1 and 10 strobes -> data offsets 0..7,0,1; done_o never pulses. Then stop_i gives done_o and IDLE.
5. play_start_i on never-recorded clip 3 -> busy_o stays 0, no mem access, no done_o. Simultaneous record_start_i and play_start_i -> RECORD entered.
6. reset_i=0 mid-RECORD after 2 samples -> IDLE, all outputs 0, length[] all 0. A following play_start_i on that clip is ignored.

Source files
------------

// File: rtl/clip_pkg.sv
// Shared types and helpers for the multi-clip record/playback sequencer.
package clip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECORD = 3'd1,
        ST_FETCH  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // Memory address is the clip index concatenated above the in-clip offset.
    function automatic logic [31:0] build_addr(input logic [31:0] clip,
                                               input logic [31:0] offset,
                                               input int          off_w);
        return (clip << off_w) | offset;
    endfunction

endpackage

// File: rtl/clip_length_table.sv
// Per-clip recorded-length register file: one write port, one async read port.
module clip_length_table #(
    parameter int NUM_CLIPS = 4,
    parameter int LEN_W     = 17
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         we_i,
    input  logic [$clog2(NUM_CLIPS)-1:0] waddr_i,
    input  logic [LEN_W-1:0]             wdata_i,
    input  logic [$clog2(NUM_CLIPS)-1:0] raddr_i,
    output logic [LEN_W-1:0]             rdata_o
);

    logic [LEN_W-1:0] len_q [NUM_CLIPS];

    // Length storage with synchronous clear.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_CLIPS; i++) begin
                len_q[i] <= '0;
            end
        end else if (we_i) begin
            len_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = len_q[raddr_i];

endmodule

// File: rtl/clip_sequencer.sv
// Multi-clip record/playback sequencer over one shared, clip-partitioned sample memory.
module clip_sequencer
    import clip_pkg::*;
#(
    parameter int WORD_LENGTH = 16,
    parameter int NUM_CLIPS   = 4,
    parameter int CLIP_DEPTH  = 65536
) (
    input  logic                                              clock_i,
    input  logic                                              reset_i,
    input  logic                                              record_start_i,
    input  logic                                              play_start_i,
    input  logic                                              stop_i,
    input  logic                                              loop_i,
    input  logic [$clog2(NUM_CLIPS)-1:0]                      clip_select_i,
    input  logic                                              rec_valid_i,
    input  logic [WORD_LENGTH-1:0]                            rec_data_i,
    input  logic                                              play_ready_i,
    output logic [WORD_LENGTH-1:0]                            play_data_o,
    output logic                                              record_enable_o,
    output logic                                              play_enable_o,
    output logic                                              mem_en_o,
    output logic                                              mem_we_o,
    output logic [$clog2(NUM_CLIPS)+$clog2(CLIP_DEPTH)-1:0]   mem_addr_o,
    output logic [WORD_LENGTH-1:0]                            mem_wdata_o,
    input  logic [WORD_LENGTH-1:0]                            mem_rdata_i,
    output logic [$clog2(NUM_CLIPS)-1:0]                      active_clip_o,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic                                              full_o
);

    localparam int CLIP_W = $clog2(NUM_CLIPS);
    localparam int OFF_W  = $clog2(CLIP_DEPTH);
    localparam int LEN_W  = OFF_W + 1;
    localparam int ADDR_W = CLIP_W + OFF_W;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(CLIP_DEPTH);

    state_e                 state_q, state_d;
    logic [CLIP_W-1:0]      clip_q, clip_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [WORD_LENGTH-1:0] play_data_q, play_data_d;
    logic                   done_q, done_d;
    logic                   full_q, full_d;

    logic                   len_we_s;
    logic [CLIP_W-1:0]      len_waddr_s;
    logic [LEN_W-1:0]       len_wdata_s;
    logic [CLIP_W-1:0]      len_raddr_s;
    logic [LEN_W-1:0]       len_rdata_s;
    logic [LEN_W-1:0]       next_len_s;
    logic                   mem_we_s;
    logic                   mem_en_s;

    // In IDLE the table answers for the requested clip, otherwise for the active one.
    assign len_raddr_s = (state_q == ST_IDLE) ? clip_select_i : clip_q;
    assign next_len_s  = {1'b0, off_q} + LEN_W'(1);

    clip_length_table #(
        .NUM_CLIPS (NUM_CLIPS),
        .LEN_W     (LEN_W)
    ) u_len_table (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (len_we_s),
        .waddr_i (len_waddr_s),
        .wdata_i (len_wdata_s),
        .raddr_i (len_raddr_s),
        .rdata_o (len_rdata_s)
    );

    // Memory port is decoded from the current state so read data lines up with LOAD.
    assign mem_we_s    = (state_q == ST_RECORD) && rec_valid_i && !stop_i;
    assign mem_en_s    = mem_we_s || (state_q == ST_FETCH);
    assign mem_en_o    = mem_en_s;
    assign mem_we_o    = mem_we_s;
    assign mem_addr_o  = mem_en_s ? ADDR_W'(build_addr(32'(clip_q), 32'(off_q), OFF_W)) : '0;
    assign mem_wdata_o = mem_we_s ? rec_data_i : '0;

    // Next-state, offset and length-table update logic.
    always_comb begin
        state_d     = state_q;
        clip_d      = clip_q;
        off_d       = off_q;
        play_data_d = play_data_q;
        done_d      = 1'b0;
        full_d      = 1'b0;
        len_we_s    = 1'b0;
        len_waddr_s = clip_q;
        len_wdata_s = '0;
        if ((state_q != ST_IDLE) && stop_i) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            play_data_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (record_start_i) begin
                        clip_d      = clip_select_i;
                        off_d       = '0;
                        len_we_s    = 1'b1;
                        len_waddr_s = clip_select_i;
                        len_wdata_s = '0;
                        state_d     = ST_RECORD;
                    end else if (play_start_i && (len_rdata_s != '0)) begin
                        clip_d  = clip_select_i;
                        off_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RECORD: begin
                    if (rec_valid_i) begin
                        len_we_s    = 1'b1;
                        len_wdata_s = next_len_s;
                        if (next_len_s == DEPTH_LEN) begin
                            full_d  = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            off_d = off_q + OFF_W'(1);
                        end
                    end else begin
                        state_d = ST_RECORD;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    play_data_d = mem_rdata_i;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (play_ready_i) begin
                        if (next_len_s == len_rdata_s) begin
                            if (loop_i) begin
                                off_d   = '0;
                                state_d = ST_FETCH;
                            end else begin
                                done_d      = 1'b1;
                                play_data_d = '0;
                                state_d     = ST_IDLE;
                            end
                        end else begin
                            off_d   = off_q + OFF_W'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered output storage.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            clip_q      <= '0;
            off_q       <= '0;
            play_data_q <= '0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clip_q      <= clip_d;
            off_q       <= off_d;
            play_data_q <= play_data_d;
            done_q      <= done_d;
            full_q      <= full_d;
        end
    end

    assign play_data_o     = play_data_q;
    assign done_o          = done_q;
    assign full_o          = full_q;
    assign active_clip_o   = clip_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign record_enable_o = (state_q == ST_RECORD);
    assign play_enable_o   = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_HOLD);

endmodule
